// File: rtl/instr_cycle_ctrl.sv
// Instruction-cycle controller for the 8-bit RISC CPU: starts on a fetch rise,
// steps eight states per instruction and emits registered control strobes.
module instr_cycle_ctrl #(
  parameter int unsigned CYCLE_STATES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       fetch,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       load_ir,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       rd,
  output logic       wr,
  output logic       datactl_ena,
  output logic       halt,
  output logic [2:0] state
);

  localparam int unsigned STATE_W = 3;
  localparam int unsigned OP_W    = 3;

  localparam logic [STATE_W-1:0] S0 = 3'd0;
  localparam logic [STATE_W-1:0] S1 = 3'd1;
  localparam logic [STATE_W-1:0] S2 = 3'd2;
  localparam logic [STATE_W-1:0] S3 = 3'd3;
  localparam logic [STATE_W-1:0] S4 = 3'd4;
  localparam logic [STATE_W-1:0] S5 = 3'd5;
  localparam logic [STATE_W-1:0] S6 = 3'd6;
  localparam logic [STATE_W-1:0] S7 = 3'd7;
  localparam logic [STATE_W-1:0] S_LAST = STATE_W'(CYCLE_STATES - 1);

  localparam logic [OP_W-1:0] OP_HLT = 3'b000;
  localparam logic [OP_W-1:0] OP_SKZ = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_AND = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_LDA = 3'b101;
  localparam logic [OP_W-1:0] OP_STO = 3'b110;
  localparam logic [OP_W-1:0] OP_JMP = 3'b111;

  logic [STATE_W-1:0] state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic               ena_q, ena_d;
  logic               halt_q, halt_d;
  logic               fetch_q;
  logic               load_ir_q, load_ir_d;
  logic               inc_pc_q, inc_pc_d;
  logic               load_pc_q, load_pc_d;
  logic               load_acc_q, load_acc_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic               dctl_q, dctl_d;

  logic               alu_op_c;
  logic [STATE_W-1:0] state_next_c;

  assign alu_op_c = (op_q == OP_ADD) || (op_q == OP_AND) ||
                    (op_q == OP_XOR) || (op_q == OP_LDA);
  assign state_next_c = (state_q == S_LAST) ? S0 : state_q + STATE_W'(1);

  // State register and registered strobes
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S0;
      op_q       <= OP_HLT;
      ena_q      <= 1'b0;
      halt_q     <= 1'b0;
      fetch_q    <= 1'b0;
      load_ir_q  <= 1'b0;
      inc_pc_q   <= 1'b0;
      load_pc_q  <= 1'b0;
      load_acc_q <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      dctl_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ena_q      <= ena_d;
      halt_q     <= halt_d;
      fetch_q    <= fetch;
      load_ir_q  <= load_ir_d;
      inc_pc_q   <= inc_pc_d;
      load_pc_q  <= load_pc_d;
      load_acc_q <= load_acc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      dctl_q     <= dctl_d;
    end
  end

  // Next state and strobe decode for the state being processed this edge
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ena_d      = ena_q | (fetch & ~fetch_q);
    halt_d     = halt_q;
    load_ir_d  = 1'b0;
    inc_pc_d   = 1'b0;
    load_pc_d  = 1'b0;
    load_acc_d = 1'b0;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    dctl_d     = 1'b0;

    if (ena_q && !halt_q) begin
      state_d = state_next_c;
      case (state_q)
        S0, S1: begin
          load_ir_d = 1'b1;
          inc_pc_d  = 1'b1;
          rd_d      = 1'b1;
        end
        S2: ;
        S3: begin
          op_d = opcode;
          if (opcode == OP_HLT) begin
            halt_d  = 1'b1;
            state_d = state_q;
          end else begin
            inc_pc_d = 1'b1;
          end
        end
        S4: begin
          rd_d      = alu_op_c;
          load_pc_d = (op_q == OP_JMP);
          dctl_d    = (op_q == OP_STO);
        end
        S5: begin
          rd_d       = alu_op_c;
          load_acc_d = alu_op_c;
          load_pc_d  = (op_q == OP_JMP);
          inc_pc_d   = (op_q == OP_JMP) || ((op_q == OP_SKZ) && zero);
          wr_d       = (op_q == OP_STO);
          dctl_d     = (op_q == OP_STO);
        end
        S6: begin
          rd_d   = alu_op_c;
          dctl_d = (op_q == OP_STO);
        end
        S7: begin
          inc_pc_d = (op_q == OP_SKZ) && zero;
        end
        default: ;
      endcase
    end
  end

  assign load_ir     = load_ir_q;
  assign inc_pc      = inc_pc_q;
  assign load_pc     = load_pc_q;
  assign load_acc    = load_acc_q;
  assign rd          = rd_q;
  assign wr          = wr_q;
  assign datactl_ena = dctl_q;
  assign halt        = halt_q;
  assign state       = state_q;

  // Bus-contention guards on the registered strobes
  a_rd_wr_excl: assert property (@(posedge clock) disable iff (reset) !(rd_q && wr_q));
  a_wr_drives:  assert property (@(posedge clock) disable iff (reset) wr_q |-> dctl_q);
  a_ldpc_jmp:   assert property (@(posedge clock) disable iff (reset) load_pc_q |-> (op_q == OP_JMP));

endmodule

// File: tb/tb_instr_cycle_ctrl.sv
// Scoreboard bench for instr_cycle_ctrl: directed instruction cycles with
// hand-tabulated strobe patterns, checked one edge after each stimulus.
module tb_instr_cycle_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       fetch = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic       zero = 1'b0;
  logic       load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  logic [10:0] exp_q[$];
  string       tag_q[$];

  localparam logic [6:0] C  = 7'b1100100;  // load_ir, inc_pc, rd
  localparam logic [6:0] I  = 7'b0100000;  // inc_pc only
  localparam logic [6:0] Z  = 7'b0000000;

  instr_cycle_ctrl #(.CYCLE_STATES(8)) dut (
    .clock(clock), .reset(reset), .fetch(fetch), .opcode(opcode), .zero(zero),
    .load_ir(load_ir), .inc_pc(inc_pc), .load_pc(load_pc), .load_acc(load_acc),
    .rd(rd), .wr(wr), .datactl_ena(datactl_ena), .halt(halt), .state(state)
  );

  always #5 clock = ~clock;

  // Vector layout: {halt, state, load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena}
  function automatic logic [10:0] ev(input logic h, input logic [2:0] st, input logic [6:0] sb);
    return {h, st, sb};
  endfunction

  task automatic step(input logic r, input logic f, input logic [2:0] op, input logic z,
                      input logic [10:0] e, input string name);
    @(negedge clock);
    reset = r; fetch = f; opcode = op; zero = z;
    exp_q.push_back(e);
    tag_q.push_back(name);
  endtask

  // Monitor: every edge that has a pending expectation is compared
  initial begin
    logic [10:0] e, act;
    string nm;
    forever begin
      @(posedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = tag_q.pop_front();
        act = {halt, state, load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena};
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL %s: got %b want %b", nm, act, e);
        end
      end
    end
  end

  // Processes n states (S0..S(n-1)); op before/at S3, op_after from S4, zero at S5/S7
  task automatic run_instr(input logic [2:0] op, input logic [2:0] op_after,
                           input logic z5, input logic z7, input int n, input string name);
    logic [6:0] tbl [8];
    case (op)
      3'b000:  tbl = '{C, C, Z, Z, Z, Z, Z, Z};
      3'b001:  tbl = '{C, C, Z, I, Z, (z5 ? I : Z), Z, (z7 ? I : Z)};
      3'b110:  tbl = '{C, C, Z, I, 7'b0000001, 7'b0000011, 7'b0000001, Z};
      3'b111:  tbl = '{C, C, Z, I, 7'b0010000, 7'b0110000, Z, Z};
      default: tbl = '{C, C, Z, I, 7'b0000100, 7'b0001100, 7'b0000100, Z};
    endcase
    for (int s = 0; s < n; s++) begin
      logic       h, z;
      logic [2:0] st, opd;
      h   = (op == 3'b000) && (s >= 3);
      st  = h ? 3'd3 : ((s == 7) ? 3'd0 : 3'(s + 1));
      opd = (s <= 3) ? op : op_after;
      z   = (s == 5) ? z5 : (s == 7) ? z7 : ~z5;
      step(1'b0, (s < 4), opd, z, ev(h, st, tbl[s]), $sformatf("%s_S%0d", name, s));
    end
  endtask

  task automatic restart(input string name);
    step(1'b0, 1'b0, 3'b010, 1'b0, ev(1'b0, 3'd0, Z), {name, "_idle"});
    step(1'b0, 1'b1, 3'b010, 1'b0, ev(1'b0, 3'd0, Z), {name, "_ena"});
  endtask

  initial begin
    step(1'b1, 1'b0, 3'b111, 1'b1, ev(1'b0, 3'd0, Z), "reset0");
    step(1'b1, 1'b1, 3'b111, 1'b1, ev(1'b0, 3'd0, Z), "reset1");
    for (int k = 0; k < 20; k++)
      step(1'b0, 1'b0, 3'(k), k[0], ev(1'b0, 3'd0, Z), $sformatf("no_fetch%0d", k));
    step(1'b0, 1'b1, 3'b010, 1'b0, ev(1'b0, 3'd0, Z), "fetch_rise");

    run_instr(3'b010, 3'b010, 1'b0, 1'b0, 8, "add");
    run_instr(3'b001, 3'b001, 1'b1, 1'b1, 8, "skz_z11");
    run_instr(3'b001, 3'b001, 1'b0, 1'b0, 8, "skz_z00");
    run_instr(3'b001, 3'b001, 1'b1, 1'b0, 8, "skz_z10");
    run_instr(3'b110, 3'b000, 1'b0, 1'b0, 8, "sto_opchg");
    run_instr(3'b111, 3'b111, 1'b1, 1'b1, 8, "jmp");
    run_instr(3'b101, 3'b111, 1'b0, 1'b1, 8, "lda");
    run_instr(3'b100, 3'b100, 1'b1, 1'b1, 8, "xor");

    // Reset mid-instruction aborts the cycle
    run_instr(3'b111, 3'b111, 1'b0, 1'b0, 5, "jmp_part");
    step(1'b1, 1'b0, 3'b111, 1'b0, ev(1'b0, 3'd0, Z), "mid_reset");
    restart("rs1");
    run_instr(3'b011, 3'b011, 1'b0, 1'b0, 8, "and");

    run_instr(3'b000, 3'b000, 1'b0, 1'b0, 4, "hlt");
    for (int k = 0; k < 30; k++)
      step(1'b0, k[0], 3'(k + 1), k[1], ev(1'b1, 3'd3, Z), $sformatf("halted%0d", k));
    step(1'b1, 1'b0, 3'b010, 1'b0, ev(1'b0, 3'd0, Z), "halt_reset");
    restart("rs2");
    run_instr(3'b010, 3'b010, 1'b0, 1'b0, 8, "add2");

    repeat (3) @(posedge clock);
    #3;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
